dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder with WAIT_STATES access latency.
// Define DMEM_MISALIGN_TRAP_EN to fault requests whose req_addr_i[1:0] != 0.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH];
  logic          fault_d;
  logic          access_d;
  logic [AW-1:0] idx_d;
  logic [31:0]   rdata_d;
  // Byte-address compare avoids a wrap when the word index exceeds the array.
`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_d = ({1'b0, addr_q} >= LIMIT) || (addr_q[1:0] != 2'b00);
`else
  assign fault_d = {1'b0, addr_q} >= LIMIT;
`endif
  assign idx_d    = addr_q[AW+1:2];
  // WAIT spans WAIT_STATES+1 cycles; the last one performs the array access.
  assign access_d = state_q == WAIT && cnt_q == 4'd0;
  assign rdata_d  = (fault_d || we_q) ? 32'd0 : mem_q[idx_d];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            be_q        <= req_be_i;
            cnt_q       <= 4'(WAIT_STATES);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (access_d) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rdata_q     <= rdata_d;
            err_q       <= fault_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Array is not reset; reset forces IDLE so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (access_d && we_q && !fault_d)
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem_q[idx_d][8*b +: 8] <= wdata_q[8*b +: 8];
  end
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed-vector bench for dmem_responder (DEPTH 1024, WAIT_STATES 1).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  // Issues one request from a negedge and returns the response and its latency in cycles.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", rsp_err); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready got %b exp 0", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sw_rsp got err %b rdata %h exp err 0 rdata 0", er, rd); end
    xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", er); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_0101 got %h exp 11bb33dd", rd); end
    xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_0000_err got %b exp 0", er); end
    xfer(1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_0000_noop got %h exp 11bb33dd", rd); end
    xfer(1'b1, 32'h24, 32'h0000BEEF, 4'b0011, rd, er, lat);
    xfer(1'b1, 32'h24, 32'hCAFE0000, 4'b1100, rd, er, lat);
    xfer(1'b0, 32'h24, 32'h0, 4'b0001, rd, er, lat);
    checks++; if (rd !== 32'hCAFEBEEF) begin errors++; $display("FAIL be_halves got %h exp cafebeef", rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
    xfer(1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_load got err %b rdata %h exp err 1 rdata 0", er, rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_latency got %0d exp 2", lat); end
    xfer(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err got %b exp 1", er); end
    xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL oor_no_wrap got %h exp cafef00d", rd); end
    xfer(1'b0, 32'hFFFFFFFC, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_top got err %b rdata %h exp err 1 rdata 0", er, rd); end
    xfer(1'b1, 32'hFFC, 32'h0BADC0DE, 4'hF, rd, er, lat);
    xfer(1'b0, 32'hFFC, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h0BADC0DE) begin errors++; $display("FAIL last_word got err %b rdata %h exp err 0 rdata 0badc0de", er, rd); end
  endtask

  task automatic test_stall;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid c%0d got %b exp 1", k, rsp_valid); end
      checks++; if (rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL stall_rdata c%0d got %h exp 12345678", k, rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL stall_err c%0d got %b exp 0", k, rsp_err); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %b exp 0", k, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got ready %b valid %b exp 1 0", req_ready, rsp_valid); end
    @(negedge clk); @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_rsp_ready got %b exp 0", rsp_valid); end
    rsp_ready = 1'b0;
    xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL stall_ignored_store got %h exp 12345678", rd); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic er; int lat; int seen;
    xfer(1'b1, 32'h40, 32'h55AA55AA, 4'hF, rd, er, lat);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL abort_clear got ready %b valid %b rdata %h err %b exp all 0", req_ready, rsp_valid, rsp_rdata, rsp_err); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d exp 0", seen); end
    xfer(1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL abort_no_write got %h exp 55aa55aa", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic er; int lat;
    xfer(1'b0, 32'h13, 32'h0, 4'hF, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL mis_load got err %b rdata %h exp err 1 rdata 0", er, rd); end
`else
    checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_load got err %b rdata %h exp err 0 rdata deadbeef", er, rd); end
`endif
    checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got %0d exp 2", lat); end
    xfer(1'b1, 32'h11, 32'h01020304, 4'b0001, rd, er, lat);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_store got %h exp deadbeef", rd); end
`else
    checks++; if (rd !== 32'hDEADBE04) begin errors++; $display("FAIL mis_store got %h exp deadbe04", rd); end
`endif
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_enable;
    test_out_of_range;
    test_stall;
    test_reset_abort;
    test_misalign;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
